// File: rtl/vram_l2_responder_pkg.sv
// ============================================================================
// Packages : attrs, cache_attrs
// Shared framebuffer/L2 geometry constants and responder state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package attrs;
    localparam int N_CORES       = 4;
    localparam int FB_ADDR_WIDTH = 14;
endpackage

package cache_attrs;
    localparam int L2_DEPTH   = 64 * attrs::N_CORES;
    localparam int VRAM_WORDS = 9600;
    localparam int L2_IDX_W   = $clog2(L2_DEPTH);
    localparam int L2_IDX_HI  = L2_IDX_W - 1;
    localparam int L2_TAG_LO  = L2_IDX_HI + 1;
    localparam int L2_TAG_W   = attrs::FB_ADDR_WIDTH - L2_TAG_LO;

    typedef logic [L2_IDX_W-1:0] l2_idx_t;
    typedef logic [L2_TAG_W-1:0] l2_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_VRAM   = 2'd2,
        ST_RESP   = 2'd3
    } l2_state_t;
endpackage

`default_nettype wire

// File: rtl/vram_l2_responder_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Combinational round-robin pick: first request at or after the pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vram_l2_responder.sv
// ============================================================================
// Module   : vram_l2_responder
// Round-robin L2 responder between per-core L1 caches and VRAM; optional
// hit/miss counters when VRAM_L2_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vram_l2_responder #(
    parameter int N_CORES  = attrs::N_CORES,
    parameter int L2_DEPTH = cache_attrs::L2_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [N_CORES-1:0]                            i_req_valid,
    input  logic [N_CORES-1:0]                            i_req_we,
    input  logic [N_CORES-1:0][attrs::FB_ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [N_CORES-1:0][63:0]                      i_req_wdata,
    output logic [N_CORES-1:0]                            o_req_ready,
    output logic [N_CORES-1:0]                            o_rsp_valid,
    output logic [63:0]                                   o_rsp_rdata,
    output logic                                          o_vram_req,
    output logic                                          o_vram_we,
    output logic [attrs::FB_ADDR_WIDTH-1:0]               o_vram_addr,
    output logic [63:0]                                   o_vram_wdata,
    input  logic                                          i_vram_ack,
    input  logic [63:0]                                   i_vram_rdata
`ifdef VRAM_L2_STATS_EN
    ,
    output logic [31:0]                                   o_hit_count,
    output logic [31:0]                                   o_miss_count
`endif
);

    localparam int AW     = attrs::FB_ADDR_WIDTH;
    localparam int IDX_W  = $clog2(L2_DEPTH);
    localparam int TAG_LO = IDX_W;
    localparam int TAG_W  = AW - TAG_LO;
    localparam int PTR_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(cache_attrs::VRAM_WORDS);

    cache_attrs::l2_state_t r_state, w_next;

    logic [PTR_W-1:0] r_ptr, r_core;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [63:0]      r_wdata, r_rdata;

    logic [L2_DEPTH-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag_mem  [L2_DEPTH];
    logic [63:0]         r_data_mem [L2_DEPTH];

    logic             r_rd_valid;
    logic [TAG_W-1:0] r_rd_tag;
    logic [63:0]      r_rd_data;

    logic [N_CORES-1:0] w_grant;
    logic [PTR_W-1:0]   w_gnt_idx, w_ptr_next;
    logic               w_any, w_take, w_in_range, w_hit, w_ack;
    logic [AW-1:0]      w_gnt_addr;
    logic [IDX_W-1:0]   w_gnt_line, w_idx;
    logic [TAG_W-1:0]   w_tag;

    rr_arbiter #(
        .N     (N_CORES),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req       (i_req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gnt_idx),
        .o_any       (w_any)
    );

    assign w_take     = (r_state == cache_attrs::ST_IDLE) && w_any;
    assign w_gnt_addr = i_req_addr[w_gnt_idx];
    assign w_gnt_line = w_gnt_addr[IDX_W-1:0];
    assign w_ptr_next = (w_gnt_idx == PTR_W'(N_CORES - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_tag      = r_addr[AW-1:TAG_LO];
    assign w_in_range = r_addr < ADDR_LIMIT;
    assign w_hit      = r_rd_valid && (r_rd_tag == w_tag);
    assign w_ack      = (r_state == cache_attrs::ST_VRAM) && i_vram_ack;

    assign o_req_ready  = w_take ? w_grant : '0;
    assign o_rsp_valid  = (r_state == cache_attrs::ST_RESP) ? (N_CORES'(1) << r_core) : '0;
    assign o_rsp_rdata  = r_rdata;
    assign o_vram_req   = (r_state == cache_attrs::ST_VRAM);
    assign o_vram_we    = r_we;
    assign o_vram_addr  = r_addr;
    assign o_vram_wdata = r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= cache_attrs::ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            cache_attrs::ST_IDLE: begin
                if (w_any) w_next = cache_attrs::ST_LOOKUP;
            end
            cache_attrs::ST_LOOKUP: begin
                if (!w_in_range || (!r_we && w_hit)) w_next = cache_attrs::ST_RESP;
                else                                 w_next = cache_attrs::ST_VRAM;
            end
            cache_attrs::ST_VRAM: begin
                if (i_vram_ack) w_next = cache_attrs::ST_RESP;
            end
            cache_attrs::ST_RESP: w_next = cache_attrs::ST_IDLE;
            default:              w_next = cache_attrs::ST_IDLE;
        endcase
    end

    // Array read is registered at grant so LOOKUP compares against stable flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_core     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_valid    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_tag   <= '0;
            r_rd_data  <= '0;
        end else begin
            if (w_take) begin
                r_core     <= w_gnt_idx;
                r_we       <= i_req_we[w_gnt_idx];
                r_addr     <= w_gnt_addr;
                r_wdata    <= i_req_wdata[w_gnt_idx];
                r_ptr      <= w_ptr_next;
                r_rd_valid <= r_valid[w_gnt_line];
                r_rd_tag   <= r_tag_mem[w_gnt_line];
                r_rd_data  <= r_data_mem[w_gnt_line];
            end
            if (r_state == cache_attrs::ST_LOOKUP) begin
                r_rdata <= (w_in_range && !r_we && w_hit) ? r_rd_data : '0;
            end
            if (w_ack) begin
                r_rdata <= r_we ? '0 : i_vram_rdata;
                if (!r_we) r_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Reads allocate; writes only refresh a line already present.
    always_ff @(posedge clk) begin
        if (w_ack && (!r_we || w_hit)) begin
            r_data_mem[w_idx] <= r_we ? r_wdata : i_vram_rdata;
            if (!r_we) r_tag_mem[w_idx] <= w_tag;
        end
    end

`ifdef VRAM_L2_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if ((r_state == cache_attrs::ST_LOOKUP) && w_in_range && !r_we) begin
            if (w_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign o_hit_count  = r_hit_cnt;
    assign o_miss_count = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vram_l2_responder.sv
// ============================================================================
// Module   : tb_vram_l2_responder
// Directed bench with a VRAM memory model and an address-level L2 model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vram_l2_responder;

    localparam int NC    = 4;
    localparam int AW    = 14;
    localparam int DEPTH = 256;
    localparam int LIMIT = 9600;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NC-1:0]          i_req_valid, i_req_we;
    logic [NC-1:0][AW-1:0]  i_req_addr;
    logic [NC-1:0][63:0]    i_req_wdata;
    logic [NC-1:0]          o_req_ready, o_rsp_valid;
    logic [63:0]            o_rsp_rdata;
    logic                   o_vram_req, o_vram_we;
    logic [AW-1:0]          o_vram_addr;
    logic [63:0]            o_vram_wdata;
    logic                   i_vram_ack   = 1'b0;
    logic [63:0]            i_vram_rdata = '0;
`ifdef VRAM_L2_STATS_EN
    logic [31:0]            o_hit_count, o_miss_count;
`endif

    vram_l2_responder #(
        .N_CORES  (NC),
        .L2_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .i_req_we     (i_req_we),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_req_ready  (o_req_ready),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_vram_req   (o_vram_req),
        .o_vram_we    (o_vram_we),
        .o_vram_addr  (o_vram_addr),
        .o_vram_wdata (o_vram_wdata),
        .i_vram_ack   (i_vram_ack),
        .i_vram_rdata (i_vram_rdata)
`ifdef VRAM_L2_STATS_EN
        ,
        .o_hit_count  (o_hit_count),
        .o_miss_count (o_miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // VRAM contents; unwritten words return an address-derived pattern
    logic [63:0] vmem [int];
    function automatic logic [63:0] vrd(input int a);
        if (vmem.exists(a)) return vmem[a];
        return {32'hC0DE_0000 | 32'(a), ~32'(a)};
    endfunction

    int rd_cnt = 0, wr_cnt = 0, ack_cyc = -1, rise_cyc = -1, lat = 0;
    bit hold_ack = 0;
    bit prev_req = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            i_vram_ack = 1'b0;
            lat        = 0;
            prev_req   = 0;
        end else begin
            if (o_vram_req && !prev_req) rise_cyc = cyc;
            prev_req = o_vram_req;
            if (i_vram_ack) begin
                i_vram_ack = 1'b0;
                lat        = 0;
            end else if (o_vram_req && !hold_ack) begin
                lat++;
                if (lat >= 2) begin
                    i_vram_ack = 1'b1;
                    ack_cyc    = cyc;
                    if (o_vram_we) begin
                        vmem[int'(o_vram_addr)] = o_vram_wdata;
                        wr_cnt++;
                        i_vram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                    end else begin
                        i_vram_rdata = vrd(int'(o_vram_addr));
                        rd_cnt++;
                    end
                end
            end
        end
    end

    // Expected VRAM transaction for the request in flight
    bit          exp_on = 0, exp_we = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [63:0] exp_wdata = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_vram_req) begin
                chk("vram_req_expected", 64'(exp_on), 64'd1);
                chk("vram_we", 64'(o_vram_we), 64'(exp_we));
                chk("vram_addr", 64'(o_vram_addr), 64'(exp_addr));
                if (exp_we) chk("vram_wdata", o_vram_wdata, exp_wdata);
            end
            if (o_rsp_valid != '0) chk("rsp_onehot", 64'($countones(o_rsp_valid)), 64'd1);
        end
    end

    // L2 model: line index -> full address currently cached there
    int m_line [int];
    int m_hits = 0, m_misses = 0;
    logic [63:0] last_rdata = '0;

    task automatic wait_txn(input int core, input bit we, input int addr,
                            input logic [63:0] wdata, input int lit_hit);
        int t, gc, rc, rd0, wr0;
        bit inr, hit, need;
        logic [63:0] exp_d;
        inr   = addr < LIMIT;
        hit   = inr && m_line.exists(addr % DEPTH) && (m_line[addr % DEPTH] == addr);
        need  = inr && (we || !hit);
        exp_d = (!inr || we) ? 64'd0 : vrd(addr);
        if (lit_hit >= 0) chk("model_hit", 64'(hit), 64'(lit_hit));
        exp_on = need; exp_we = we; exp_addr = AW'(addr); exp_wdata = wdata;
        rd0 = rd_cnt; wr0 = wr_cnt;
        t = 0;
        do begin @(negedge clk); t++; end while (o_req_ready == '0 && t < 50);
        gc = cyc;
        chk("grant", 64'(o_req_ready), 64'(1 << core));
        @(posedge clk);
        #1 i_req_valid[core] = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (o_rsp_valid == '0 && t < 50);
        rc = cyc;
        chk("rsp_core", 64'(o_rsp_valid), 64'(1 << core));
        if (!we) chk("rsp_rdata", o_rsp_rdata, exp_d);
        last_rdata = o_rsp_rdata;
        chk("vram_reads", 64'(rd_cnt - rd0), 64'(need && !we));
        chk("vram_writes", 64'(wr_cnt - wr0), 64'(need && we));
        if (need) begin
            chk("vram_req_rise", 64'(rise_cyc - gc), 64'd2);
            chk("rsp_after_ack", 64'(rc - ack_cyc), 64'd1);
        end else begin
            chk("rsp_latency", 64'(rc - gc), 64'd2);
        end
        exp_on = 0;
        if (inr && !we) begin
            m_line[addr % DEPTH] = addr;
            if (hit) m_hits++; else m_misses++;
        end
    endtask

    task automatic do_req(input int core, input bit we, input int addr,
                          input logic [63:0] wdata, input int lit_hit);
        @(posedge clk);
        #1;
        i_req_we[core]    = we;
        i_req_addr[core]  = AW'(addr);
        i_req_wdata[core] = wdata;
        i_req_valid[core] = 1'b1;
        wait_txn(core, we, addr, wdata, lit_hit);
    endtask

    initial begin
        int  t;
        bit  seen;
        i_req_valid = '0;
        i_req_we    = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(o_req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 64'd0);
        chk("rst_vram_req", 64'(o_vram_req), 64'd0);
        chk("rst_vram_we", 64'(o_vram_we), 64'd0);
        chk("rst_vram_addr", 64'(o_vram_addr), 64'd0);
        chk("rst_vram_wdata", o_vram_wdata, 64'd0);
        rst_n = 1'b1;
`ifdef VRAM_L2_STATS_EN
        chk("rst_hit_count", 64'(o_hit_count), 64'd0);
        chk("rst_miss_count", 64'(o_miss_count), 64'd0);
`endif

        // Cold miss, then hit
        vmem[16] = 64'hDEADBEEF_00000001;
        do_req(0, 1'b0, 16, 64'd0, 0);
        chk("cold_read_data", last_rdata, 64'hDEADBEEF_00000001);
        do_req(0, 1'b0, 16, 64'd0, 1);
        chk("hit_read_data", last_rdata, 64'hDEADBEEF_00000001);

        // Write-through on a cached line, then read hit sees new data
        do_req(2, 1'b1, 16, 64'h1122334455667788, 1);
        do_req(1, 1'b0, 16, 64'd0, 1);
        chk("read_after_write", last_rdata, 64'h1122334455667788);

        // Same-index conflict evicts
        do_req(0, 1'b0, 'h110, 64'd0, 0);
        do_req(0, 1'b0, 'h010, 64'd0, 0);
        do_req(0, 1'b0, 'h110, 64'd0, 0);

        // Address limit boundary
        do_req(3, 1'b0, LIMIT, 64'd0, 0);
        chk("oor_data", last_rdata, 64'd0);
        do_req(3, 1'b0, LIMIT - 1, 64'd0, 0);

        // Write miss must not allocate
        do_req(1, 1'b1, 'h300, 64'h0000_0000_0000_CAFE, 0);
        do_req(1, 1'b0, 'h300, 64'd0, 0);
        chk("write_miss_then_read", last_rdata, 64'h0000_0000_0000_CAFE);

        // Reset while VRAM access is pending
        hold_ack = 1;
        exp_on = 1; exp_we = 0; exp_addr = AW'(16'h40); exp_wdata = '0;
        @(posedge clk);
        #1;
        i_req_we[0] = 1'b0; i_req_addr[0] = AW'(16'h40); i_req_valid[0] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (o_req_ready == '0 && t < 50);
        @(posedge clk);
        #1 i_req_valid[0] = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_vram_req && t < 50);
        chk("vram_req_before_reset", 64'(o_vram_req), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("vram_req_async_drop", 64'(o_vram_req), 64'd0);
        exp_on = 0;
        m_line.delete();
        m_hits = 0; m_misses = 0;
        hold_ack = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_rsp_valid != '0) seen = 1;
        end
        chk("no_rsp_after_reset", 64'(seen), 64'd0);
`ifdef VRAM_L2_STATS_EN
        chk("post_reset_hit_count", 64'(o_hit_count), 64'd0);
        chk("post_reset_miss_count", 64'(o_miss_count), 64'd0);
`endif

        // All cores at once from reset: grants 0,1,2,3
        @(posedge clk);
        #1;
        i_req_we    = '0;
        i_req_addr[0] = AW'(16'h40);
        i_req_addr[1] = AW'(16'h10);
        i_req_addr[2] = AW'(16'h22);
        i_req_addr[3] = AW'(16'h23);
        i_req_valid = '1;
        wait_txn(0, 1'b0, 'h40, 64'd0, 0);
        wait_txn(1, 1'b0, 'h10, 64'd0, 0);
        wait_txn(2, 1'b0, 'h22, 64'd0, 0);
        wait_txn(3, 1'b0, 'h23, 64'd0, 0);
        do_req(0, 1'b0, 'h40, 64'd0, 1);
`ifdef VRAM_L2_STATS_EN
        chk("final_hit_count", 64'(o_hit_count), 64'(m_hits));
        chk("final_miss_count", 64'(o_miss_count), 64'(m_misses));
        chk("final_hit_literal", 64'(o_hit_count), 64'd1);
        chk("final_miss_literal", 64'(o_miss_count), 64'd4);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
